pkt_buf_writer: RTL and testbench
=================================

PKT_BUF_WRITER -- requirements
Module: pkt_buf_writer

Interface
REQ-001 SHALL have parameter MAX_PKT_FLITS, default 24, max flits per packet (1536 B).
REQ-002 SHALL have parameter DESC_DEPTH, default 8, descriptor queue entries (power of 2).
REQ-003 SHALL have a single clock and a synchronous active-high reset; ports clk and rst.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_sop / in_eop / in_valid  in  1 each  registered Ethernet-in framing; no backpressure.
REQ-007 in_data  in  512  flit payload; in_empty  in  6  unused bytes on EOP flit.
REQ-008 esram_pkt_buf_wren  out  1  packet-buffer write strobe.
REQ-009 esram_pkt_buf_wraddress  out  PKTBUF_AWIDTH  flit write address.
REQ-010 esram_pkt_buf_wrdata  out  520  {sop, eop, empty[5:0], data[511:0]}, MSB first.
REQ-011 desc_valid  out  1; desc_ready  in  1; desc_addr  out  PKTBUF_AWIDTH  first-flit address; desc_nflits  out  5  flit count.
REQ-012 free_valid  in  1; free_nflits  in  5  flits released by the downstream reader.
REQ-013 pkt_cnt, drop_cnt  out  32 each  accepted / dropped packet counters.

Function
REQ-014 SHALL implement FSM IDLE, WRITE, DROP.
REQ-015 IDLE, in_valid&in_sop: accept if free_flits >= MAX_PKT_FLITS and descriptor queue not full -> WRITE (or single-flit packet completes immediately); else -> DROP and drop_cnt+1.
REQ-016 DROP: discard flits; in_valid&in_eop -> IDLE.
REQ-017 IDLE, in_valid without in_sop: discard flit, no counter change.
REQ-018 Each accepted flit SHALL produce wren=1 exactly one cycle later at wr_ptr, then wr_ptr+1 modulo 2^PKTBUF_AWIDTH (wraps to 0).
REQ-019 free_flits SHALL decrement by 1 per written flit and increment by free_nflits on free_valid; both in one cycle SHALL net correctly; width PKTBUF_AWIDTH+1.
REQ-020 On accepted EOP, descriptor {start address, nflits} SHALL be pushed; desc_valid SHALL rise the cycle after the EOP write; pkt_cnt+1 same cycle.
REQ-021 Descriptor handshake: transfer when desc_valid&desc_ready; desc_addr/desc_nflits SHALL hold stable while desc_valid&!desc_ready.
REQ-022 Oversize: if flit MAX_PKT_FLITS+1 arrives without EOP, SHALL stop writing, restore wr_ptr to packet start, restore free_flits, drop_cnt+1, -> DROP (or IDLE if that flit has EOP).
REQ-023 SOP during WRITE: abort current packet as REQ-022 (rollback, drop_cnt+1), then evaluate new SOP per REQ-015 same cycle.
REQ-024 Rolled-back flits already written SHALL not be reported; no descriptor issued for them.
REQ-025 Counters SHALL wrap at 2^32.

Reset
REQ-026 Reset SHALL force: state IDLE, wr_ptr 0, free_flits 2^PKTBUF_AWIDTH, wren 0, desc_valid 0, queue empty, pkt_cnt 0, drop_cnt 0; wraddress/wrdata SHALL be 0.
REQ-027 Reset mid-packet SHALL discard the partial packet without descriptor; post-reset flits before next SOP are discarded per REQ-017.

Structure
REQ-028 PKTBUF_AWIDTH and the 520-bit flit layout field offsets SHALL live in the shared constants package.
REQ-029 Descriptor queue SHALL be sub-module pkt_desc_fifo (DESC_DEPTH entries, show-ahead, full/empty flags).

Verification
REQ-030 Single 1-flit packet (sop=eop=1, empty=4) after reset -> wren at addr 0, wrdata[519:512]={1,1,6'd4}, descriptor {0,1}, pkt_cnt=1.
REQ-031 Back-to-back 3-flit packets with desc_ready=1 -> addrs 0..5, descriptors {0,3},{3,3}, free_flits=2^AW-6.
REQ-032 Fill buffer with desc_ready=0 until descriptor queue full (8) -> 9th packet dropped, drop_cnt=1, no wren.
REQ-033 Free space < 24, then free_valid with free_nflits=24 same cycle as a written flit -> free_flits net +23; next SOP accepted.
REQ-034 25-flit packet without EOP -> wr_ptr restored to start, drop_cnt=1, no descriptor; next packet reuses same start address.
REQ-035 Pointer near 2^AW-1 with 3-flit packet -> addresses wrap to 0, descriptor addr = 2^AW-1, nflits 3.

Source files
------------

// File: rtl/pkt_buf_writer_pkg.sv
// Shared constants for the packet-buffer writer: buffer address width, flit layout, descriptor type.
// The flit word is {sop, eop, empty[5:0], data[511:0]}, MSB first.
package pkt_buf_writer_pkg;

    localparam int PKTBUF_AWIDTH  = 6;
    localparam int DATA_W         = 512;
    localparam int EMPTY_W        = 6;
    localparam int NFLITS_W       = 5;
    localparam int FLIT_W         = 520;
    localparam int FLIT_DATA_LSB  = 0;
    localparam int FLIT_EMPTY_LSB = 512;
    localparam int FLIT_EOP_BIT   = 518;
    localparam int FLIT_SOP_BIT   = 519;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic [PKTBUF_AWIDTH-1:0] addr;
        logic [NFLITS_W-1:0]      nflits;
    } pkt_desc_t;

    function automatic logic [FLIT_W-1:0] pack_flit(
        input logic               sop,
        input logic               eop,
        input logic [EMPTY_W-1:0] empty,
        input logic [DATA_W-1:0]  data
    );
        logic [FLIT_W-1:0] f;
        f                               = '0;
        f[FLIT_SOP_BIT]                 = sop;
        f[FLIT_EOP_BIT]                 = eop;
        f[FLIT_EMPTY_LSB +: EMPTY_W]    = empty;
        f[FLIT_DATA_LSB +: DATA_W]      = data;
        return f;
    endfunction

endpackage

// File: rtl/pkt_desc_fifo.sv
// Show-ahead descriptor queue between the packet writer and the downstream reader.
// The head entry is visible whenever empty is low; pop advances it.
module pkt_desc_fifo
    import pkt_buf_writer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  pkt_desc_t                  push_desc,
    input  logic                       pop,
    output pkt_desc_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    pkt_desc_t       mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_desc;
    end

endmodule

// File: rtl/pkt_buf_writer.sv
// Writes incoming Ethernet flits into the packet buffer and queues one descriptor per good packet.
//   state    | meaning
//   ST_IDLE  | between packets; non-SOP flits discarded
//   ST_WRITE | packet accepted, flits being written
//   ST_DROP  | packet rejected or aborted; discard until EOP
module pkt_buf_writer
    import pkt_buf_writer_pkg::*;
#(
    parameter int MAX_PKT_FLITS = 24,
    parameter int DESC_DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_sop,
    input  logic                       in_eop,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [EMPTY_W-1:0]         in_empty,
    output logic                       esram_pkt_buf_wren,
    output logic [PKTBUF_AWIDTH-1:0]   esram_pkt_buf_wraddress,
    output logic [FLIT_W-1:0]          esram_pkt_buf_wrdata,
    output logic                       desc_valid,
    input  logic                       desc_ready,
    output logic [PKTBUF_AWIDTH-1:0]   desc_addr,
    output logic [NFLITS_W-1:0]        desc_nflits,
    input  logic                       free_valid,
    input  logic [NFLITS_W-1:0]        free_nflits,
    output logic [31:0]                pkt_cnt,
    output logic [31:0]                drop_cnt
);
    localparam int FW = PKTBUF_AWIDTH + 1;
    localparam int LW = $clog2(DESC_DEPTH) + 1;
    localparam logic [FW-1:0]       FREE_RESET  = FW'(1 << PKTBUF_AWIDTH);
    localparam logic [FW-1:0]       MAX_FLITS_F = FW'(MAX_PKT_FLITS);
    localparam logic [NFLITS_W-1:0] MAX_FLITS_N = NFLITS_W'(MAX_PKT_FLITS);

    wr_state_e                state;
    logic [PKTBUF_AWIDTH-1:0] wr_ptr;
    logic [FW-1:0]            free_flits;
    logic [PKTBUF_AWIDTH-1:0] pkt_start;
    logic [NFLITS_W-1:0]      pkt_nflits;
    logic                     push_pend;
    pkt_desc_t                push_desc;

    pkt_desc_t                q_head;
    logic                     q_full;
    logic                     q_empty;
    logic [LW-1:0]            q_level;

    logic                     in_pkt;
    logic                     abort;
    logic                     oversize;
    logic                     rollback;
    logic                     sop_eval;
    logic                     q_room;
    logic                     accept;
    logic                     cont;
    logic                     write_flit;
    logic [PKTBUF_AWIDTH-1:0] base_ptr;
    logic [FW-1:0]            base_free;
    logic [FW-1:0]            free_inc;
    logic [FW-1:0]            free_next;
    logic [31:0]              n_drops;

    pkt_desc_fifo #(
        .DEPTH (DESC_DEPTH)
    ) u_desc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_pend),
        .push_desc (push_desc),
        .pop       (desc_ready),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .level     (q_level)
    );

    assign desc_valid  = !q_empty;
    assign desc_addr   = q_head.addr;
    assign desc_nflits = q_head.nflits;

    // An abort or oversize rolls pointer and space back first, so a new SOP in
    // the same cycle is judged against the restored values.
    always_comb begin
        in_pkt     = (state == ST_WRITE) && in_valid;
        abort      = in_pkt && in_sop;
        oversize   = in_pkt && !in_sop && (pkt_nflits == MAX_FLITS_N);
        rollback   = abort || oversize;
        base_ptr   = rollback ? pkt_start : wr_ptr;
        base_free  = rollback ? (free_flits + FW'(pkt_nflits)) : free_flits;
        sop_eval   = in_valid && in_sop && (state != ST_DROP);
        // A descriptor still in the push register counts against queue space.
        q_room     = !q_full && ((LW + 1)'(q_level) + (LW + 1)'(push_pend) < (LW + 1)'(DESC_DEPTH));
        accept     = sop_eval && (base_free >= MAX_FLITS_F) && q_room;
        cont       = in_pkt && !in_sop && !oversize;
        write_flit = accept || cont;
        free_inc   = free_valid ? FW'(free_nflits) : '0;
        free_next  = base_free - FW'(write_flit) + free_inc;
        n_drops    = 32'(rollback) + 32'(sop_eval && !accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= ST_IDLE;
            wr_ptr                  <= '0;
            free_flits              <= FREE_RESET;
            pkt_start               <= '0;
            pkt_nflits              <= '0;
            push_pend               <= 1'b0;
            push_desc               <= '0;
            esram_pkt_buf_wren      <= 1'b0;
            esram_pkt_buf_wraddress <= '0;
            esram_pkt_buf_wrdata    <= '0;
            pkt_cnt                 <= '0;
            drop_cnt                <= '0;
        end else begin
            esram_pkt_buf_wren <= write_flit;
            if (write_flit) begin
                esram_pkt_buf_wraddress <= base_ptr;
                esram_pkt_buf_wrdata    <= pack_flit(in_sop, in_eop, in_empty, in_data);
            end
            wr_ptr     <= base_ptr + PKTBUF_AWIDTH'(write_flit);
            free_flits <= free_next;
            drop_cnt   <= drop_cnt + n_drops;
            pkt_cnt    <= pkt_cnt + 32'(push_pend);
            push_pend  <= write_flit && in_eop;

            if (accept) begin
                pkt_start  <= base_ptr;
                pkt_nflits <= NFLITS_W'(1);
            end else if (cont) begin
                pkt_nflits <= pkt_nflits + NFLITS_W'(1);
            end

            if (write_flit && in_eop) begin
                push_desc.addr   <= accept ? base_ptr : pkt_start;
                push_desc.nflits <= accept ? NFLITS_W'(1) : pkt_nflits + NFLITS_W'(1);
            end

            case (state)
                ST_IDLE, ST_WRITE: begin
                    if (in_valid) begin
                        if (in_sop) begin
                            if (in_eop)      state <= ST_IDLE;
                            else if (accept) state <= ST_WRITE;
                            else             state <= ST_DROP;
                        end else if (state == ST_WRITE) begin
                            if (oversize)    state <= in_eop ? ST_IDLE : ST_DROP;
                            else if (in_eop) state <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (in_valid && in_eop) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_buf_writer.sv
// Scoreboard bench for pkt_buf_writer: a packet-level reference model queues expected
// buffer writes and descriptors; a negedge monitor pops and compares them.
module tb_pkt_buf_writer;
    import pkt_buf_writer_pkg::*;

    localparam int AW    = PKTBUF_AWIDTH;
    localparam int NBUF  = 1 << AW;
    localparam int MAXF  = 24;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0;
    logic [511:0]      in_data = '0;
    logic [5:0]        in_empty = '0;
    logic              wren;
    logic [AW-1:0]     wraddress;
    logic [519:0]      wrdata;
    logic              desc_valid;
    logic              desc_ready = 1'b0;
    logic [AW-1:0]     desc_addr;
    logic [4:0]        desc_nflits;
    logic              free_valid = 1'b0;
    logic [4:0]        free_nflits = '0;
    logic [31:0]       pkt_cnt, drop_cnt;

    always #5 clk = ~clk;

    pkt_buf_writer #(.MAX_PKT_FLITS(MAXF), .DESC_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid),
        .in_data(in_data), .in_empty(in_empty),
        .esram_pkt_buf_wren(wren), .esram_pkt_buf_wraddress(wraddress),
        .esram_pkt_buf_wrdata(wrdata),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_nflits(desc_nflits),
        .free_valid(free_valid), .free_nflits(free_nflits),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct { int addr; logic [519:0] data; } wr_exp_t;
    typedef struct { int addr; int nflits; } desc_exp_t;

    wr_exp_t   wr_q[$];
    desc_exp_t desc_q[$];
    int n_vec = 0, n_bad = 0;
    int pops = 0, pool = 0;

    // Reference model: packet open/discarding, start address, flits so far, space left.
    int  m_mode = 0;   // 0 between packets, 1 packet open, 2 discarding to EOP
    int  m_wr = 0, m_free = NBUF, m_start = 0, m_cnt = 0, m_issued = 0;
    int  m_pkts = 0, m_drops = 0;
    bit  auto_free = 0, rdy_rand = 0, rdy_fixed = 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        wr_q.delete(); desc_q.delete();
        pops = 0; pool = 0;
        m_mode = 0; m_wr = 0; m_free = NBUF; m_start = 0; m_cnt = 0;
        m_issued = 0; m_pkts = 0; m_drops = 0;
    endtask

    task automatic model_flit(input bit s, input bit e, input logic [5:0] emp, input logic [511:0] d);
        bit      wr_it;
        wr_exp_t w;
        desc_exp_t de;
        wr_it = 0;
        if (s && m_mode != 2) begin
            if (m_mode == 1) begin
                m_wr = m_start; m_free += m_cnt; m_drops++; m_mode = 0;
            end
            if (m_free >= MAXF && (m_issued - pops) < DEPTH) begin
                m_mode = 1; m_start = m_wr; m_cnt = 0; wr_it = 1;
            end else begin
                m_drops++; m_mode = e ? 0 : 2;
            end
        end else if (m_mode == 1) begin
            if (m_cnt == MAXF) begin
                m_wr = m_start; m_free += m_cnt; m_drops++; m_mode = e ? 0 : 2;
            end else begin
                wr_it = 1;
            end
        end else if (m_mode == 2 && e) begin
            m_mode = 0;
        end
        if (wr_it) begin
            w.addr = m_wr; w.data = {s, e, emp, d};
            wr_q.push_back(w);
            m_wr = (m_wr + 1) % NBUF; m_free--; m_cnt++;
            if (e) begin
                de.addr = m_start; de.nflits = m_cnt;
                desc_q.push_back(de);
                m_issued++; m_pkts++; m_mode = 0;
            end
        end
    endtask

    // One clock of stimulus; ffree > 0 forces a release of that many flits.
    task automatic step(input bit v, input bit s, input bit e, input int ffree);
        logic [511:0] d;
        logic [5:0]   emp;
        int           fn;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        emp = 6'($urandom_range(0, 63));
        fn = 0;
        if (ffree > 0) fn = ffree;
        else if (auto_free && pool > 0 && $urandom_range(0, 3) == 0)
            fn = (pool < 31) ? $urandom_range(1, pool) : $urandom_range(1, 31);
        rst = 1'b0;
        in_valid = v; in_sop = s; in_eop = e; in_data = d; in_empty = emp;
        desc_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        free_valid = (fn > 0); free_nflits = 5'(fn);
        pool -= fn;
        if (v) model_flit(s, e, emp, d);
        m_free += fn;
    endtask

    task automatic send_pkt(input int len, input bit with_eop, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps) while ($urandom_range(0, 4) == 0) step(0, 0, 0, 0);
            step(1, i == 0, with_eop && (i == len - 1), 0);
        end
    endtask

    task automatic drain(input int n);
        bit sv_rand, sv_fixed;
        sv_rand = rdy_rand; sv_fixed = rdy_fixed;
        rdy_rand = 0; rdy_fixed = 1;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
        rdy_rand = sv_rand; rdy_fixed = sv_fixed;
    endtask

    task automatic check_counters(input string tag);
        drain(14);
        @(negedge clk);
        chk({tag, "_pkt_cnt"},  pkt_cnt,  m_pkts);
        chk({tag, "_drop_cnt"}, drop_cnt, m_drops);
        chk({tag, "_wr_pending"},   wr_q.size(),   0);
        chk({tag, "_desc_pending"}, desc_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 0; in_sop = 0; in_eop = 0;
        desc_ready = 0; free_valid = 0; free_nflits = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_wren", wren, 0);
        chk("rst_desc_valid", desc_valid, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_wraddress", wraddress, 0);
        chk("rst_wrdata_top", wrdata[519:504], 0);
    endtask

    // Monitor: compare every buffer write and every descriptor transfer.
    logic          hold_v = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [4:0]    hold_n;
    always @(negedge clk) begin
        wr_exp_t   w;
        desc_exp_t de;
        if (rst !== 1'b0) begin
            hold_v = 1'b0;
        end else begin
            if (wren === 1'b1) begin
                n_vec++;
                if (wr_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_wren addr got=%0d want=none", wraddress);
                end else begin
                    w = wr_q.pop_front();
                    if (wraddress !== AW'(w.addr) || wrdata !== w.data) begin
                        n_bad++;
                        $display("FAIL wr addr got=%0d want=%0d hdr got=%h want=%h data_ok=%0d",
                                 wraddress, w.addr, wrdata[519:512], w.data[519:512],
                                 wrdata[511:0] === w.data[511:0]);
                    end
                end
            end
            if (hold_v) begin
                n_vec++;
                if (desc_valid !== 1'b1 || desc_addr !== hold_addr || desc_nflits !== hold_n) begin
                    n_bad++;
                    $display("FAIL desc_hold got=%0d/%0d/%0d want=1/%0d/%0d",
                             desc_valid, desc_addr, desc_nflits, hold_addr, hold_n);
                end
            end
            if (desc_valid === 1'b1 && desc_ready) begin
                n_vec++;
                pops++;
                if (desc_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_desc got=%0d/%0d want=none", desc_addr, desc_nflits);
                end else begin
                    de = desc_q.pop_front();
                    pool += de.nflits;
                    if (desc_addr !== AW'(de.addr) || desc_nflits !== 5'(de.nflits)) begin
                        n_bad++;
                        $display("FAIL desc got=%0d/%0d want=%0d/%0d",
                                 desc_addr, desc_nflits, de.addr, de.nflits);
                    end
                end
            end
            hold_v    = (desc_valid === 1'b1) && !desc_ready;
            hold_addr = desc_addr;
            hold_n    = desc_nflits;
        end
    end

    initial begin
        // single-flit packet
        do_reset();
        step(1, 1, 1, 0);
        in_empty = 6'd4;
        wr_q[wr_q.size()-1].data[517:512] = 6'd4;
        check_counters("one_flit");
        chk("one_flit_pkt_cnt_abs", pkt_cnt, 1);

        // back-to-back 3-flit packets
        do_reset();
        send_pkt(3, 1, 0); send_pkt(3, 1, 0);
        check_counters("b2b");
        chk("b2b_pkt_cnt_abs", pkt_cnt, 2);
        chk("b2b_free_model", m_free, NBUF - 6);

        // descriptor queue full
        do_reset();
        rdy_fixed = 0;
        for (int i = 0; i < 9; i++) send_pkt(1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        @(negedge clk);
        chk("qfull_drop_cnt", drop_cnt, 1);
        chk("qfull_desc_valid", desc_valid, 1);
        rdy_fixed = 1;
        check_counters("qfull");

        // release in the same cycle as a written flit while space is low
        do_reset();
        send_pkt(20, 1, 0); send_pkt(14, 1, 0);
        drain(6);
        for (int i = 0; i < 10; i++) step(1, i == 0, i == 9, (i == 7) ? 24 : 0);
        chk("net_free_model", m_free, NBUF - 44 + 24);
        send_pkt(3, 1, 0);
        check_counters("net_free");
        chk("net_free_drops_abs", drop_cnt, 0);

        // oversize packet rolls back
        do_reset();
        send_pkt(25, 0, 0);
        step(1, 0, 1, 0);
        send_pkt(2, 1, 0);
        check_counters("oversize");
        chk("oversize_drop_abs", drop_cnt, 1);
        chk("oversize_pkt_abs", pkt_cnt, 1);

        // pointer wrap
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send_pkt(21, 1, 0);
            drain(4);
            step(0, 0, 0, 21);
        end
        chk("wrap_start_model", m_wr, NBUF - 1);
        send_pkt(3, 1, 0);
        check_counters("wrap");

        // reset in the middle of a packet
        do_reset();
        send_pkt(5, 0, 0);
        step(0, 0, 0, 0);
        do_reset();
        step(1, 0, 0, 0); step(1, 0, 1, 0);
        send_pkt(2, 1, 0);
        check_counters("midrst");

        // randomized traffic
        do_reset();
        auto_free = 1; rdy_rand = 1;
        for (int p = 0; p < 300; p++) begin
            int kind;
            kind = $urandom_range(0, 15);
            if (kind == 0) step(1, 0, $urandom_range(0, 1), 0);
            else if (kind == 1) send_pkt($urandom_range(1, 30), 0, 1);
            else if (kind == 2) send_pkt($urandom_range(24, 27), 1, 0);
            else send_pkt($urandom_range(1, 12), 1, $urandom_range(0, 1));
            if (p % 50 == 49) check_counters("rand");
        end
        auto_free = 0; rdy_rand = 0;
        send_pkt(1, 1, 0);
        check_counters("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
